alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request queue depth in entries (power of 2, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles from ALU issue to result capture (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port aclr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  queue can accept a request.
REQ-007 SHALL have port req_op  input  3  operation code.
REQ-008 SHALL have ports req_a and req_b  input  8 each  operands.
REQ-009 SHALL have ports alu_in_1 and alu_in_2  output  8 each  ALU operands.
REQ-010 SHALL have port alu_func  output  3  ALU function select.
REQ-011 SHALL have port alu_enable  output  1  ALU enable.
REQ-012 SHALL have port alu_aclr  output  1  ALU clear.
REQ-013 SHALL have port alu_out  input  16  ALU result.
REQ-014 SHALL have ports zero_flag and overflow  input  1 each  ALU flags.
REQ-015 SHALL have port rsp_valid  output  1  response present.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-017 SHALL have port rsp_data  output  16  result.
REQ-018 SHALL have ports rsp_op  output  3, rsp_zero  output  1, rsp_ovf  output  1, rsp_err  output  1  echoed op, flags, illegal-op error.
REQ-019 SHALL have port busy  output  1  FSM not in IDLE or queue non-empty.

Function
REQ-020 SHALL accept a request in a cycle with req_valid=1 and req_ready=1; req_ready=1 iff queue count < FIFO_DEPTH.
REQ-021 SHALL store requests in a FIFO_DEPTH-entry FIFO of {op,a,b}, with wrapping pointers and push/pop in the same cycle allowed when full (count unchanged).
REQ-022 SHALL run FSM states IDLE, ISSUE, WAIT, CAPTURE, RESP.
REQ-023 SHALL go IDLE->ISSUE when the queue is non-empty, popping the head entry into working registers.
REQ-024 SHALL, in ISSUE, drive alu_enable=1 with operands and func per REQ-028 and go to WAIT, or go to CAPTURE when ALU_LAT=1.
REQ-025 SHALL stay in WAIT for ALU_LAT-1 cycles with a down-counter, then go to CAPTURE.
REQ-026 SHALL hold alu_enable=1, alu_func, alu_in_1 and alu_in_2 stable from ISSUE through CAPTURE, and drive alu_enable=0 otherwise.
REQ-027 SHALL, in CAPTURE, register rsp_data<=alu_out, rsp_zero<=zero_flag, rsp_ovf<=overflow, rsp_op<=op and rsp_err<=0, then go to RESP.
REQ-028 SHALL map ops as: 000 add, 001 mul, 010 and, 011 or, 100 xor, 101 less-than, each passed through as alu_func with in_1=a and in_2=b.
REQ-029 SHALL map op 110 (shift-left) to alu_func=001 with in_1=a and in_2=8'h01<<b[2:0] (b[7:3] ignored), so the result is a<<b[2:0] zero-extended to 16 bits.
REQ-030 SHALL handle op 111 (illegal) by skipping the ALU: ISSUE goes directly to RESP with rsp_data=0, rsp_zero=1, rsp_ovf=0, rsp_err=1 and alu_enable staying 0.
REQ-031 SHALL assert rsp_valid only in RESP and hold all rsp_* stable until rsp_ready=1.
REQ-032 SHALL, on a RESP handshake, go to ISSUE (popping the next entry) if the queue is non-empty, else to IDLE, giving zero bubble between back-to-back responses.
REQ-033 SHALL, when the queue is empty, accept a push in IDLE and reach ISSUE in the next cycle; the minimum request-accept to rsp_valid latency is ALU_LAT+2 cycles.
REQ-034 SHALL drive alu_aclr as aclr OR'd with a one-cycle registered pulse after aclr deasserts.

Reset
REQ-035 SHALL, while aclr=1 (asynchronous, including mid-operation), clear the FIFO (count 0, pointers 0), set FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_zero=0, rsp_ovf=0, rsp_err=0, alu_enable=0, alu_func=0, alu_in_1=0, alu_in_2=0, busy=0, req_ready=0, and alu_aclr=1.
REQ-036 SHALL discard in-flight and queued requests on reset without producing a response.
REQ-037 SHALL make req_ready=1 from the first clock edge after aclr deasserts.

Verification
REQ-038 Bench SHALL check: op 000, a=8'hFF, b=8'h01 -> rsp_data=16'h0100, rsp_err=0, rsp_valid ALU_LAT+2 cycles after accept.
REQ-039 Bench SHALL check: op 110, a=8'h81, b=8'h0B -> alu_func=001, alu_in_2=8'h08, rsp_data=16'h0408.
REQ-040 Bench SHALL check: op 111 -> rsp_err=1, rsp_data=0, rsp_zero=1, alu_enable never 1.
REQ-041 Bench SHALL check: push 5 requests with rsp_ready=0 (FIFO_DEPTH=4) -> req_ready=0 after 4 queued plus 1 in RESP; then set rsp_ready=1 -> all 5 responses in order with no lost requests.
REQ-042 Bench SHALL check: assert aclr while in WAIT with ALU_LAT=3 -> rsp_valid=0 and busy=0 immediately, no response for the flushed request, req_ready=1 one cycle after release.
REQ-043 Bench SHALL check: op 010, a=8'h0F, b=8'hF0 with ALU zero_flag=1 -> rsp_data=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_sequencer                                                |
// | Description : Queues {op,a,b} requests, sequences them through an external |
// |               ALU and returns registered responses with flags and error.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [7:0]  alu_in_1,
    output logic [7:0]  alu_in_2,
    output logic [2:0]  alu_func,
    output logic        alu_enable,
    output logic        alu_aclr,
    input  logic [15:0] alu_out,
    input  logic        zero_flag,
    input  logic        overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_op,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        busy
);

    localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W  = $clog2(ALU_LAT + 1);
    localparam logic [c_PTR_W:0]   c_FULL   = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT0  = c_CNT_W'(ALU_LAT - 2);
    localparam logic [2:0]         c_OP_SHL = 3'b110;
    localparam logic [2:0]         c_OP_ILL = 3'b111;
    localparam logic [2:0]         c_FN_MUL = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t               r_state;
    logic [18:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_rdy_en;
    logic                 r_aclr_pulse;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic [2:0]           r_op;

    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_op;
    logic [7:0]           w_a;
    logic [7:0]           w_b;
    logic [2:0]           w_func;
    logic [7:0]           w_in_1;
    logic [7:0]           w_in_2;

    assign req_ready = r_rdy_en && (r_count != c_FULL);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
    assign alu_aclr  = aclr | r_aclr_pulse;

    assign {w_op, w_a, w_b} = r_mem[r_rd_ptr];

    // Shift-left reuses the multiplier with a one-hot power of two.
    always_comb begin
        w_func = w_op;
        w_in_1 = w_a;
        w_in_2 = w_b;
        if (w_op == c_OP_SHL) begin
            w_func = c_FN_MUL;
            w_in_2 = 8'h01 << w_b[2:0];
        end else if (w_op == c_OP_ILL) begin
            w_func = 3'b000;
            w_in_1 = 8'h00;
            w_in_2 = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_op, req_a, req_b};
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rdy_en     <= 1'b0;
            r_aclr_pulse <= 1'b1;
        end else begin
            r_rdy_en     <= 1'b1;
            r_aclr_pulse <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_op       <= 3'b000;
            alu_enable <= 1'b0;
            alu_func   <= 3'b000;
            alu_in_1   <= 8'h00;
            alu_in_2   <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_data   <= 16'h0000;
            rsp_op     <= 3'b000;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if ((r_state == S_IDLE) || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_op       <= w_op;
                            alu_enable <= (w_op != c_OP_ILL);
                            alu_func   <= w_func;
                            alu_in_1   <= w_in_1;
                            alu_in_2   <= w_in_2;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_op == c_OP_ILL) begin
                        rsp_data  <= 16'h0000;
                        rsp_zero  <= 1'b1;
                        rsp_ovf   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_op    <= r_op;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (ALU_LAT == 1) begin
                        r_state   <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= c_WAIT0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    rsp_data   <= alu_out;
                    rsp_zero   <= zero_flag;
                    rsp_ovf    <= overflow;
                    rsp_op     <= r_op;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    alu_enable <= 1'b0;
                    r_state    <= S_RESP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_sequencer                                             |
// | Description : Directed self-checking bench for alu_sequencer with a        |
// |               behavioural ALU model.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_sequencer;

    localparam int c_DEPTH = 4;
    localparam int c_LAT   = 3;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [7:0]  req_a = 8'h00;
    logic [7:0]  req_b = 8'h00;
    logic [7:0]  alu_in_1;
    logic [7:0]  alu_in_2;
    logic [2:0]  alu_func;
    logic        alu_enable;
    logic        alu_aclr;
    logic [15:0] alu_out;
    logic        zero_flag;
    logic        overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    alu_sequencer #(.FIFO_DEPTH(c_DEPTH), .ALU_LAT(c_LAT)) u_dut (
        .clk(clk), .aclr(aclr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_func(alu_func),
        .alu_enable(alu_enable), .alu_aclr(alu_aclr),
        .alu_out(alu_out), .zero_flag(zero_flag), .overflow(overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: inputs are held stable for the whole issue window.
    always_comb begin
        case (alu_func)
            3'd0:    alu_out = {8'h00, alu_in_1} + {8'h00, alu_in_2};
            3'd1:    alu_out = {8'h00, alu_in_1} * {8'h00, alu_in_2};
            3'd2:    alu_out = {8'h00, alu_in_1 & alu_in_2};
            3'd3:    alu_out = {8'h00, alu_in_1 | alu_in_2};
            3'd4:    alu_out = {8'h00, alu_in_1 ^ alu_in_2};
            3'd5:    alu_out = {15'h0000, alu_in_1 < alu_in_2};
            default: alu_out = 16'h0000;
        endcase
        zero_flag = (alu_out == 16'h0000);
        overflow  = (alu_func == 3'd0) && alu_out[8];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("push_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic take_rsp(output logic [15:0] d, output logic [2:0] op, output logic z,
                            output logic o, output logic e, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        d = rsp_data;
        op = rsp_op;
        z = rsp_zero;
        o = rsp_ovf;
        e = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [15:0] d;
    logic [2:0]  op;
    logic        z, o, e;
    int          lat;
    logic        seen;

    logic [2:0]  v_op  [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
    logic [7:0]  v_a   [5] = '{8'd3, 8'd10, 8'hA0, 8'hFF, 8'd2};
    logic [7:0]  v_b   [5] = '{8'd4, 8'd10, 8'h05, 8'h0F, 8'd9};
    logic [15:0] v_exp [5] = '{16'h0007, 16'h0064, 16'h00A5, 16'h00F0, 16'h0001};

    initial begin
        #2;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_alu_aclr", {31'd0, alu_aclr}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_alu_enable", {31'd0, alu_enable}, 32'd0);
        check_eq("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        #20;
        aclr = 1'b0;
        tick();
        check_eq("rel_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check_eq("rel_alu_aclr_low", {31'd0, alu_aclr}, 32'd0);

        // Add with carry out, and minimum latency.
        push(3'd0, 8'hFF, 8'h01);
        take_rsp(d, op, z, o, e, lat);
        check_eq("add_latency", lat, c_LAT + 2);
        check_eq("add_data", {16'd0, d}, 32'h0100);
        check_eq("add_err", {31'd0, e}, 32'd0);
        check_eq("add_ovf", {31'd0, o}, 32'd1);
        check_eq("add_op", {29'd0, op}, 32'd0);
        check_eq("add_after_valid", {31'd0, rsp_valid}, 32'd0);

        // Shift-left through the multiplier.
        push(3'd6, 8'h81, 8'h0B);
        for (int i = 0; i < 10 && !alu_enable; i++) tick();
        check_eq("shl_enable", {31'd0, alu_enable}, 32'd1);
        check_eq("shl_func", {29'd0, alu_func}, 32'd1);
        check_eq("shl_in_1", {24'd0, alu_in_1}, 32'h81);
        check_eq("shl_in_2", {24'd0, alu_in_2}, 32'h08);
        tick();
        check_eq("shl_in_2_held", {24'd0, alu_in_2}, 32'h08);
        take_rsp(d, op, z, o, e, lat);
        check_eq("shl_data", {16'd0, d}, 32'h0408);
        check_eq("shl_op", {29'd0, op}, 32'd6);

        // Illegal op never touches the ALU.
        push(3'd7, 8'h12, 8'h34);
        seen = alu_enable;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            tick();
            if (alu_enable) seen = 1'b1;
        end
        take_rsp(d, op, z, o, e, lat);
        check_eq("ill_err", {31'd0, e}, 32'd1);
        check_eq("ill_data", {16'd0, d}, 32'd0);
        check_eq("ill_zero", {31'd0, z}, 32'd1);
        check_eq("ill_ovf", {31'd0, o}, 32'd0);
        check_eq("ill_enable_seen", {31'd0, seen}, 32'd0);

        // AND giving zero result.
        push(3'd2, 8'h0F, 8'hF0);
        take_rsp(d, op, z, o, e, lat);
        check_eq("and_data", {16'd0, d}, 32'd0);
        check_eq("and_zero", {31'd0, z}, 32'd1);

        // Fill queue with response stalled, then drain in order.
        for (int i = 0; i < 5; i++) push(v_op[i], v_a[i], v_b[i]);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        check_eq("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("full_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("full_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("full_rsp_stable", {16'd0, rsp_data}, {16'd0, v_exp[0]});
        begin
            int k = 0;
            rsp_ready = 1'b1;
            for (int c = 0; c < 100 && k < 5; c++) begin
                if (rsp_valid) begin
                    check_eq($sformatf("drain_data_%0d", k), {16'd0, rsp_data}, {16'd0, v_exp[k]});
                    check_eq($sformatf("drain_op_%0d", k), {29'd0, rsp_op}, {29'd0, v_op[k]});
                    k++;
                end
                tick();
            end
            rsp_ready = 1'b0;
            check_eq("drain_count", k, 5);
        end
        tick();
        check_eq("drain_idle_busy", {31'd0, busy}, 32'd0);

        // Reset while waiting on the ALU.
        push(3'd0, 8'h01, 8'h02);
        for (int i = 0; i < 10 && !alu_enable; i++) tick();
        tick();
        #2;
        aclr = 1'b1;
        #1;
        check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_enable", {31'd0, alu_enable}, 32'd0);
        check_eq("mid_rst_alu_aclr", {31'd0, alu_aclr}, 32'd1);
        tick();
        #3;
        aclr = 1'b0;
        #1;
        check_eq("mid_rel_req_ready_low", {31'd0, req_ready}, 32'd0);
        check_eq("mid_rel_aclr_pulse", {31'd0, alu_aclr}, 32'd1);
        tick();
        check_eq("mid_rel_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("mid_rel_aclr_done", {31'd0, alu_aclr}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check_eq("mid_rst_no_rsp", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
